// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls, flushes and EX-aligned forwarding selects.
// Optional performance counters are enabled by defining HAZ_PERF_EN.
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              regwrite_ex,
    input  logic              memread_ex,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              regwrite_mem,
    input  logic              branch_taken_ex,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_err
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = TIMEOUT[CW-1:0];

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          timeout_hit;

    logic hit_ex_1, hit_ex_2, hit_mem_1, hit_mem_2, load_use;

    assign hit_ex_1  = use_rs1_id & regwrite_ex  & (rd_ex  != '0) & (rd_ex  == rs1_id);
    assign hit_ex_2  = use_rs2_id & regwrite_ex  & (rd_ex  != '0) & (rd_ex  == rs2_id);
    assign hit_mem_1 = use_rs1_id & regwrite_mem & (rd_mem != '0) & (rd_mem == rs1_id);
    assign hit_mem_2 = use_rs2_id & regwrite_mem & (rd_mem != '0) & (rd_mem == rs2_id);
    assign load_use  = memread_ex & (hit_ex_1 | hit_ex_2);

    // Priority: memory wait, then taken branch, then load-use. Everything is quiet during reset.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        timeout_hit = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                        state_nxt = MEM_WAIT;
                        cnt_nxt   = CW'(1);
                    end else if (branch_taken_ex) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else if (cnt == TMO) begin
                        // Give up: release the pipeline now and flag the error next cycle.
                        timeout_hit = 1'b1;
                        state_nxt   = RUN;
                        cnt_nxt     = '0;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                        cnt_nxt   = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
        if (hit_ex)       fwd_sel = 2'b10;
        else if (hit_mem) fwd_sel = 2'b01;
        else              fwd_sel = 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            cnt     <= '0;
            fwd_a   <= 2'b00;
            fwd_b   <= 2'b00;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mem_err <= timeout_hit;
            // Selects follow the ID instruction into EX, so they hold whenever ID/EX holds.
            if (!stall_ex) begin
                if (flush_ex) begin
                    fwd_a <= 2'b00;
                    fwd_b <= 2'b00;
                end else begin
                    fwd_a <= fwd_sel(hit_ex_1, hit_mem_1);
                    fwd_b <= fwd_sel(hit_ex_2, hit_mem_2);
                end
            end
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_if && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            // flush_id is raised only by a taken branch.
            if (flush_id && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT=4): driver pushes expected outputs per cycle, negedge monitor compares.
module tb_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rs1_id, rs2_id, rd_ex, rd_mem;
    logic          use_rs1_id, use_rs2_id, regwrite_ex, memread_ex, regwrite_mem;
    logic          branch_taken_ex, mem_req, mem_ready;
    logic          stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_err;
    logic [1:0]    fwd_a, fwd_b;
`ifdef HAZ_PERF_EN
    logic [31:0]   perf_stall_cyc, perf_flush_cnt;
`endif

    hazard_ctrl #(.REG_AW(AW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .rd_ex(rd_ex), .regwrite_ex(regwrite_ex), .memread_ex(memread_ex),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
        .branch_taken_ex(branch_taken_ex),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err)
`ifdef HAZ_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard
    logic [10:0] exp_q[$];
    string       name_q[$];
    logic        chk = 1'b0;
    int          total = 0;
    int          bad = 0;

    wire [10:0] obs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
                       fwd_a, fwd_b, mem_err};

    function automatic logic [10:0] mk(input logic [3:0] st, input logic fid, input logic fex,
                                       input logic [1:0] fa, input logic [1:0] fb, input logic me);
        mk = {st, fid, fex, fa, fb, me};
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL monitor: got %b with empty expected queue", obs);
            end else begin
                logic [10:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (obs !== e) begin
                    bad++;
                    $display("FAIL %s: got {st,fid,fex,fa,fb,err}=%b required %b", nm, obs, e);
                end
            end
        end
    end

    // Driver tasks
    task automatic clr_in();
        rs1_id = '0; rs2_id = '0; rd_ex = '0; rd_mem = '0;
        use_rs1_id = 1'b0; use_rs2_id = 1'b0;
        regwrite_ex = 1'b0; memread_ex = 1'b0; regwrite_mem = 1'b0;
        branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic [10:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk = 1'b1;
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic mem_wait_in(input logic rdy);
        mem_req = 1'b1; mem_ready = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        clr_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // while still in reset: mem wait request must not stall
        mem_wait_in(1'b0);
        cyc("reset_quiet", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
        clr_in();
        rst = 1'b0;

        // Load-use on x5, then MEM forward once the load has moved on
        memread_ex = 1; regwrite_ex = 1; rd_ex = 5; rs1_id = 5; use_rs1_id = 1;
        cyc("load_use", mk(4'b1100, 0, 1, 2'b00, 2'b00, 0));
        clr_in(); rs1_id = 5; use_rs1_id = 1; rd_mem = 5; regwrite_mem = 1;
        cyc("load_in_mem", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
        clr_in();
        cyc("fwd_a_mem", mk(4'b0000, 0, 0, 2'b01, 2'b00, 0));

        // x7 written by both EX and MEM: EX wins
        rd_ex = 7; regwrite_ex = 1; rd_mem = 7; regwrite_mem = 1; rs2_id = 7; use_rs2_id = 1;
        cyc("dual_hit_issue", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
        rd_ex = 0; rd_mem = 0; rs2_id = 0;
        cyc("fwd_b_ex_prio", mk(4'b0000, 0, 0, 2'b00, 2'b10, 0));
        clr_in();
        cyc("fwd_b_x0", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));

        // MEM-only hit on both operands
        rd_mem = 3; regwrite_mem = 1; rs1_id = 3; rs2_id = 3; use_rs1_id = 1; use_rs2_id = 1;
        cyc("mem_hit_issue", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
        clr_in();
        cyc("fwd_ab_mem", mk(4'b0000, 0, 0, 2'b01, 2'b01, 0));

        // Load in EX but ID does not read the register: no hazard
        memread_ex = 1; regwrite_ex = 1; rd_ex = 4; rs1_id = 4;
        cyc("no_use_no_stall", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
        clr_in();
        cyc("no_use_no_fwd", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));

        // Branch beats load-use
        memread_ex = 1; regwrite_ex = 1; rd_ex = 5; rs1_id = 5; use_rs1_id = 1; branch_taken_ex = 1;
        cyc("branch_over_lu", mk(4'b0000, 1, 1, 2'b00, 2'b00, 0));
        clr_in();

        // Three wait cycles, ID/EX hit held until the ready cycle
        rd_ex = 9; regwrite_ex = 1; rs1_id = 9; use_rs1_id = 1;
        mem_wait_in(1'b0);
        cyc("wait_1", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
        cyc("wait_2", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
        cyc("wait_3", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
        mem_ready = 1;
        cyc("wait_ready", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
        clr_in(); mem_wait_in(1'b1);
        cyc("run_ready_same_cyc", mk(4'b0000, 0, 0, 2'b10, 2'b00, 0));
        clr_in();

        // Timeout after four stalled cycles
        mem_wait_in(1'b0);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("tmo_stall_%0d", i), mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
        cyc("tmo_release", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
        clr_in();
        cyc("tmo_err_pulse", mk(4'b0000, 0, 0, 2'b00, 2'b00, 1));
        cyc("tmo_err_clear", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));

        // Branch held across a wait is flushed in the first RUN cycle
        branch_taken_ex = 1; mem_wait_in(1'b0);
        cyc("br_wait_1", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
        cyc("br_wait_2", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
        mem_ready = 1;
        cyc("br_wait_ready", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
        mem_req = 0; mem_ready = 0;
        cyc("br_flush_after", mk(4'b0000, 1, 1, 2'b00, 2'b00, 0));
        clr_in();
        cyc("br_done", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));

        // Reset in the middle of a wait
        rd_ex = 6; regwrite_ex = 1; rs1_id = 6; use_rs1_id = 1;
        cyc("pre_rst_hit", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
        clr_in(); mem_wait_in(1'b0);
        cyc("rst_wait_1", mk(4'b1111, 0, 0, 2'b10, 2'b00, 0));
        cyc("rst_wait_2", mk(4'b1111, 0, 0, 2'b10, 2'b00, 0));
        rst = 1'b1;
        cyc("rst_drops_stall", mk(4'b0000, 0, 0, 2'b10, 2'b00, 0));
        rst = 1'b0; clr_in(); branch_taken_ex = 1;
        cyc("rst_back_in_run", mk(4'b0000, 1, 1, 2'b00, 2'b00, 0));
`ifdef HAZ_PERF_EN
        total++;
        if (perf_stall_cyc !== 32'd0 || perf_flush_cnt !== 32'd1) begin
            bad++;
            $display("FAIL perf_after_rst: got stall=%0d flush=%0d required stall=0 flush=1",
                     perf_stall_cyc, perf_flush_cnt);
        end
`endif
        clr_in();
        cyc("idle_end", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d leftover entries required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
